// File: rtl/alu_cmp_pkg.sv
`default_nettype none
// ============================================================================
// alu_cmp_pkg : relation codes and scan-FSM state type shared with ALU flags
// Revision    : 1.0
// ============================================================================
package alu_cmp_pkg;

    typedef logic [1:0] cmp_code_t;

    localparam cmp_code_t CMP_EQ = 2'b00;
    localparam cmp_code_t CMP_LT = 2'b01;
    localparam cmp_code_t CMP_GT = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } cmp_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_msb_comparator_if.sv
`default_nettype none
// ============================================================================
// serial_msb_comparator_if : start/busy/done handshake and result bundle
// Revision                 : 1.0
// ============================================================================
interface serial_msb_comparator_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [1:0]       z;
    logic             gt;
    logic             lt;
    logic             eq;
    logic [CNT_W-1:0] nbits;

    modport master (
        output start, a, b,
        input  busy, done, z, gt, lt, eq, nbits
    );

    modport slave (
        input  start, a, b,
        output busy, done, z, gt, lt, eq, nbits
    );
endinterface
`default_nettype wire

// File: rtl/cmp_bit_decide.sv
`default_nettype none
// ============================================================================
// cmp_bit_decide : single-bit compare giving {differ, relation code}
// Revision       : 1.0
// ============================================================================
module cmp_bit_decide
    import alu_cmp_pkg::*;
(
    input  wire logic a_bit,
    input  wire logic b_bit,
    output cmp_code_t rel,
    output logic      differ
);
    always_comb begin
        rel    = CMP_EQ;
        differ = a_bit ^ b_bit;
        if (a_bit && !b_bit) begin
            rel = CMP_GT;
        end else if (!a_bit && b_bit) begin
            rel = CMP_LT;
        end
    end
endmodule
`default_nettype wire

// File: rtl/serial_msb_comparator.sv
`default_nettype none
// ============================================================================
// serial_msb_comparator : MSB-first bit-serial magnitude compare, early exit
// Revision              : 1.0
// ============================================================================
module serial_msb_comparator
    import alu_cmp_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input wire logic               clk,
    input wire logic               rst,
    serial_msb_comparator_if.slave bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    cmp_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    cmp_code_t        z_q, z_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] nbits_q, nbits_d;

    cmp_code_t        w_rel;
    logic             w_differ;

    cmp_bit_decide u_bit_decide (
        .a_bit  (a_q[idx_q]),
        .b_bit  (b_q[idx_q]),
        .rel    (w_rel),
        .differ (w_differ)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        z_d     = z_q;
        valid_d = valid_q;
        nbits_d = nbits_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = IDX_W'(WIDTH - 1);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Stop on the first differing bit, or after the LSB regardless.
                if (w_differ || (idx_q == '0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    z_d     = w_rel;
                    valid_d = 1'b1;
                    nbits_d = CNT_W'(WIDTH) - CNT_W'(idx_q);
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            z_q     <= CMP_EQ;
            valid_q <= 1'b0;
            nbits_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            z_q     <= z_d;
            valid_q <= valid_d;
            nbits_q <= nbits_d;
        end
    end

    // eq is qualified so a cleared code after reset does not read as "equal".
    assign bus.busy  = (state_q == SCAN);
    assign bus.done  = done_q;
    assign bus.z     = z_q;
    assign bus.gt    = z_q[1];
    assign bus.lt    = z_q[0];
    assign bus.eq    = ~z_q[1] & ~z_q[0] & valid_q;
    assign bus.nbits = nbits_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_msb_comparator.sv
`default_nettype none
// ============================================================================
// tb_serial_msb_comparator : directed + random compares against integer model
// Revision                 : 1.0
// ============================================================================
module tb_serial_msb_comparator;
    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_msb_comparator_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    serial_msb_comparator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [1:0] prev_z;
    int         prev_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Position (1-based from MSB) of the first differing bit, WIDTH if equal.
    function automatic int first_diff(input int av, input int bv);
        int x;
        x = av ^ bv;
        if (x == 0) return WIDTH;
        return WIDTH + 1 - $clog2(x + 1);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(bus.busy),  0);
        check({tag, "_done"},  32'(bus.done),  0);
        check({tag, "_z"},     32'(bus.z),     0);
        check({tag, "_gt"},    32'(bus.gt),    0);
        check({tag, "_lt"},    32'(bus.lt),    0);
        check({tag, "_eq"},    32'(bus.eq),    0);
        check({tag, "_nbits"}, 32'(bus.nbits), 0);
    endtask

    // Called at a negedge; returns at the negedge where done is observed.
    task automatic compare(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input bit disturb);
        int k, edges, busy_cnt;
        logic [1:0] ez;
        ez = (int'(av) > int'(bv)) ? 2'b10 : (int'(av) < int'(bv)) ? 2'b01 : 2'b00;
        k  = first_diff(int'(av), int'(bv));
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(negedge clk);
        bus.start = 1'b0;
        check("done_low_after_accept", 32'(bus.done), 0);
        check("z_held_on_start", 32'(bus.z), 32'(prev_z));
        check("nbits_held_on_start", 32'(bus.nbits), 32'(prev_n));
        edges    = 0;
        busy_cnt = 0;
        while (edges < WIDTH + 2) begin
            if (bus.busy) busy_cnt++;
            if (disturb) begin
                if (edges == 0) begin
                    bus.start = 1'b1;
                    bus.a     = '0;
                    bus.b     = '1;
                end else begin
                    bus.start = 1'($urandom);
                    bus.a     = WIDTH'($urandom);
                    bus.b     = WIDTH'($urandom);
                end
            end
            @(negedge clk);
            edges++;
            if (bus.done) break;
        end
        bus.start = 1'b0;
        check("done_seen", 32'(bus.done), 1);
        check("latency", 32'(edges), 32'(k));
        check("busy_cycles", 32'(busy_cnt), 32'(k));
        check("busy_low_at_done", 32'(bus.busy), 0);
        check("z", 32'(bus.z), 32'(ez));
        check("gt", 32'(bus.gt), 32'(ez == 2'b10));
        check("lt", 32'(bus.lt), 32'(ez == 2'b01));
        check("eq", 32'(bus.eq), 32'(av == bv));
        check("nbits", 32'(bus.nbits), 32'(k));
        prev_z = ez;
        prev_n = k;
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        prev_z    = 2'b00;
        prev_n    = 0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("eq_before_first_compare", 32'(bus.eq), 0);

        compare(4'b1010, 4'b0101, 1'b0);
        compare(4'b0110, 4'b0111, 1'b0);
        compare(4'b1001, 4'b1001, 1'b0);
        compare(4'b0011, 4'b0001, 1'b1);
        compare(4'b1100, 4'b1101, 1'b0);

        // Reset two edges into a full-length scan.
        bus.start = 1'b1;
        bus.a     = 4'b0001;
        bus.b     = 4'b0000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("mid_scan_reset");
        @(negedge clk);
        rst    = 1'b0;
        prev_z = 2'b00;
        prev_n = 0;
        for (int i = 0; i < WIDTH + 1; i++) begin
            @(negedge clk);
            check("no_done_after_abort", 32'(bus.done), 0);
        end
        check("idle_after_abort", 32'(bus.busy), 0);
        compare(4'b1000, 4'b0000, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            rb = ($urandom_range(3) == 0) ? ra : WIDTH'($urandom);
            if ($urandom_range(2) == 0) @(negedge clk);
            compare(ra, rb, 1'($urandom));
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/serial_msb_comparator.md
Name: serial_msb_comparator

Overview:
- Sequential magnitude comparator for the ALU datapath.
- Scans two WIDTH-bit unsigned operands MSB-first, one bit per clock, and stops at the first differing bit.
- Produces the same 2-bit relation code as the ALU's LSB-first ripple comparison chain, so downstream flag logic is shared.
- Sits beside the ALU as a low-area compare unit, controlled by a start/busy/done handshake.

Parameters:
- WIDTH, 4, operand width in bits; legal range is 1 or more.
- CNT_W, $clog2(WIDTH+1), width of the bits-examined counter output.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- busy  out  1  high while scanning.
- done  out  1  one-cycle pulse when a result is updated.
- z  out  2  relation code: 2'b10 = A>B, 2'b01 = A<B, 2'b00 = A==B.
- gt  out  1  decoded A>B.
- lt  out  1  decoded A<B.
- eq  out  1  decoded A==B; valid only after the first done.
- nbits  out  CNT_W  number of bit positions examined for the last result (1..WIDTH).

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. While rst=1, all outputs are 0 (busy, done, z, gt, lt, eq, nbits) and the FSM is IDLE.
- IDLE state:
  - busy=0.
  - If start=1 at a rising edge: latch a and b into internal regs, set idx=WIDTH-1, go to SCAN.
  - done is deasserted on the accept edge unless a result is produced on that same edge, which cannot happen from IDLE.
- SCAN state:
  - busy=1. Each edge examines bit idx of the latched operands.
  - If a[idx]=1 and b[idx]=0: z<=10, go to IDLE.
  - If a[idx]=0 and b[idx]=1: z<=01, go to IDLE.
  - If the bits are equal and idx==0: z<=00, go to IDLE.
  - Otherwise: idx<=idx-1 and stay in SCAN.
  - On any transition to IDLE: done<=1 for exactly one cycle, nbits<=WIDTH-idx, and gt/lt/eq update together with z.
- Latency: done goes high k edges after the accept edge, where k is the position of the first differing bit counted from the MSB (1-based), or k=WIDTH if the operands are equal. Best case is 1 edge, worst case WIDTH edges.
- Results: z, gt, lt, eq and nbits hold until the next done. They are not cleared on start.
- gt/lt/eq decode: gt=z[1], lt=z[0], eq=~z[1]&~z[0]&result_valid. result_valid is an internal flag set by the first done and cleared by rst.
- Back-to-back: start is accepted in the cycle where done=1, because the FSM is already IDLE. This allows a new compare every k+1 cycles.
- start while busy is ignored; the latched operands do not change.
- a and b changing during SCAN have no effect.
- Reset mid-SCAN: immediate return to IDLE, all outputs 0, the scan is abandoned, and no done is produced.
- WIDTH=1: every compare takes exactly 1 edge and nbits=1.
- The idx counter never wraps. SCAN exits at idx==0 unconditionally.

Decomposition:
- Shared package alu_cmp_pkg holds:
  - The relation code constants CMP_EQ=2'b00, CMP_LT=2'b01, CMP_GT=2'b10.
  - The FSM state type {IDLE, SCAN}, for reuse by the ALU flag logic.
- One natural sub-module, cmp_bit_decide:
  - Combinational function of (a_bit, b_bit) giving {differ, relation code}.
  - Instantiated once in the SCAN datapath.
- Everything else stays in the top module.

Test Plan (WIDTH=4):
- Early exit: start with a=1010, b=0101 -> done 1 edge after accept; z=10, gt=1, nbits=1; busy high for 1 cycle.
- Full-length less-than: a=0110, b=0111 -> done after 4 edges; z=01, lt=1, eq=0, nbits=4.
- Equal operands: a=1001, b=1001 -> done after 4 edges; z=00, eq=1, gt=lt=0, nbits=4. Also confirm eq=0 after reset before any compare.
- Busy protection: start a=0011, b=0001, then on the next cycle pulse start with a=0000, b=1111 and change a/b -> the second start is ignored; done after 3 edges with z=10, nbits=3.
- Back-to-back: assert start with a=1100, b=1101 in the done cycle of the previous compare -> accepted; second done after 4 edges with z=01. done never stays high for 2 consecutive cycles.
- Reset mid-scan: start a=0001, b=0000, assert rst asynchronously after 2 edges -> all outputs 0 immediately; no done; the next start a=1000, b=0000 gives z=10 after 1 edge.
